// File: rtl/shifter_seq_pkg.sv
// Shared definitions for the sequential shifter.
// Holds the opcode constants carried on the Signal input, the FSM state
// encoding, and a helper that tells supported opcodes from the rest.
package shifter_seq_pkg;

  localparam logic [5:0] OP_SLL = 6'b000010;
  localparam logic [5:0] OP_SRL = 6'b000011;
  localparam logic [5:0] OP_SRA = 6'b000100;
  localparam logic [5:0] OP_ROR = 6'b000101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_valid_op(input logic [5:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shifter_seq_shift_step.sv
// shift_step: one combinational shift of the working register.
// Ports:
//   data_i  WIDTH  value to shift
//   k_i     KW     positions to shift this cycle (0..STEP)
//   op_i    6      opcode (SLL/SRL/SRA/ROR); anything else passes data_i through
//   fill_i  1      sign bit used as the SRA fill
//   data_o  WIDTH  shifted value
module shift_step
  import shifter_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [KW-1:0]    k_i,
  input  logic [5:0]       op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] ones;
  logic [31:0]      rot_amt;

  always_comb begin
    ones    = '1;
    // A left shift by WIDTH yields zero, so k=0 rotates to data_i unchanged.
    rot_amt = 32'(WIDTH) - 32'(k_i);
    data_o  = data_i;
    case (op_i)
      OP_SLL: data_o = data_i << k_i;
      OP_SRL: data_o = data_i >> k_i;
      // Top k bits that the logical shift vacated get the latched sign.
      OP_SRA: data_o = (data_i >> k_i) | (fill_i ? ~(ones >> k_i) : '0);
      OP_ROR: data_o = (data_i >> k_i) | (data_i << rot_amt);
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle barrel-less shifter, at most STEP positions per cycle.
// Ports:
//   clk      1      clock, rising edge
//   reset    1      synchronous active-high reset
//   start    1      request, accepted in IDLE or DONE only
//   dataA    WIDTH  operand
//   dataB    WIDTH  shift amount (low log2(WIDTH) bits used)
//   Signal   6      opcode (SLL/SRL/SRA/ROR)
//   busy     1      high while shifting
//   done     1      one-cycle pulse, dataOut valid
//   dataOut  WIDTH  registered result, held until next done or reset
module shifter_seq
  import shifter_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  localparam int CW = $clog2(WIDTH);
  localparam int KW = $clog2(STEP) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [5:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [KW-1:0]    k;
  logic [31:0]      rem_ext;
  logic [31:0]      rem_left;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-CW-1:0] unused_datab;

  assign unused_datab = dataB[WIDTH-1:CW];

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .data_i (work_q),
    .k_i    (k),
    .op_i   (op_q),
    .fill_i (fill_q),
    .data_o (stepped)
  );

  always_comb begin
    rem_ext  = 32'(rem_q);
    k        = (rem_ext >= 32'(STEP)) ? KW'(STEP) : KW'(rem_q);
    rem_left = rem_ext - 32'(k);

    state_d = state_q;
    work_d  = work_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    op_d    = op_q;
    fill_d  = fill_q;

    case (state_q)
      ST_SHIFT: begin
        work_d = stepped;
        rem_d  = CW'(rem_left);
        if (rem_left == 32'd0) begin
          state_d = ST_DONE;
          dout_d  = is_valid_op(op_q) ? stepped : '0;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_SHIFT;
          work_d  = dataA;
          // Unsupported opcodes get a zero count so they finish after one cycle.
          rem_d   = is_valid_op(Signal) ? dataB[CW-1:0] : '0;
          op_d    = Signal;
          fill_d  = dataA[WIDTH-1];
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataOut = dout_q;

endmodule
